// File: rtl/perm_scan_ctrl.sv
// Scan sequencer for the permutation-cost datapath: sweeps the worker index per
// permutation and emits accumulate strobes aligned to the cost-lookup pipeline.
module perm_scan_ctrl #(
  parameter int N_WORKER = 8,
  parameter int IDX_W    = 3,
  parameter int PIPE_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             perm_valid,
  input  logic             perm_last,
  output logic             perm_ready,
  output logic [IDX_W-1:0] worker_idx,
  output logic             issue,
  output logic             acc_en,
  output logic             acc_first,
  output logic             acc_last,
  output logic [CNT_W-1:0] perm_count,
  output logic             busy,
  output logic             out_valid
);

  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(N_WORKER - 1);
  localparam logic [DW-1:0]    DRAIN_MAX = DW'(PIPE_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_SCAN  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic             last_q, last_next;
  logic [DW-1:0]    drain_cnt, drain_next;
  logic [CNT_W-1:0] count_next;
  logic             count_inc, count_clr;
  logic [2:0]       tap;
  logic [2:0]       pipe [PIPE_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      last_q     <= 1'b0;
      drain_cnt  <= '0;
      perm_count <= '0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      last_q     <= last_next;
      drain_cnt  <= drain_next;
      perm_count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    last_next  = last_q;
    drain_next = drain_cnt;
    count_inc  = 1'b0;
    count_clr  = 1'b0;
    perm_ready = 1'b0;
    issue      = 1'b0;
    worker_idx = '0;
    out_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_WAIT;
          count_clr  = 1'b1;
        end
      end
      S_WAIT: begin
        perm_ready = perm_valid;
        if (perm_valid) begin
          last_next  = perm_last;
          idx_next   = '0;
          count_inc  = 1'b1;
          state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        issue      = 1'b1;
        worker_idx = idx;
        if (idx == IDX_MAX) begin
          if (last_q) begin
            state_next = S_DRAIN;
            drain_next = '0;
          end else if (perm_valid) begin
            // Back-to-back: take the next permutation on the final index, no bubble.
            perm_ready = 1'b1;
            idx_next   = '0;
            last_next  = perm_last;
            count_inc  = 1'b1;
          end else begin
            state_next = S_WAIT;
          end
        end else begin
          idx_next = idx + IDX_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DRAIN_MAX) begin
          state_next = S_DONE;
        end else begin
          drain_next = drain_cnt + DW'(1);
        end
      end
      S_DONE: begin
        out_valid  = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    if (count_clr) begin
      count_next = '0;
    end else if (count_inc && (perm_count != {CNT_W{1'b1}})) begin
      count_next = perm_count + CNT_W'(1);
    end else begin
      count_next = perm_count;
    end
  end

  // Markers are gated by issue so acc_first/acc_last can never appear without acc_en.
  assign tap = {issue, issue && (idx == '0), issue && (idx == IDX_MAX)};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= 3'b000;
    end else begin
      pipe[0] <= tap;
      for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign acc_en    = pipe[PIPE_LAT-1][2];
  assign acc_first = pipe[PIPE_LAT-1][1];
  assign acc_last  = pipe[PIPE_LAT-1][0];
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_perm_scan_ctrl.sv
// Scoreboard bench for perm_scan_ctrl: stimulus pushes expected index/strobe/done
// values into queues, negedge monitors pop and compare as the DUTs present them.
module tb_perm_scan_ctrl;
  localparam int NW = 8;
  localparam int PL = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, perm_valid, perm_last;
  logic perm_ready, issue, acc_en, acc_first, acc_last, busy, out_valid;
  logic [2:0] worker_idx;
  logic [15:0] perm_count;

  logic start_b, perm_valid_b, perm_last_b;
  logic perm_ready_b, issue_b, acc_en_b, acc_first_b, acc_last_b, busy_b, out_valid_b;
  logic [2:0] worker_idx_b;
  logic [1:0] perm_count_b;

  perm_scan_ctrl #(.N_WORKER(8), .IDX_W(3), .PIPE_LAT(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .start(start), .perm_valid(perm_valid), .perm_last(perm_last),
    .perm_ready(perm_ready), .worker_idx(worker_idx), .issue(issue), .acc_en(acc_en),
    .acc_first(acc_first), .acc_last(acc_last), .perm_count(perm_count), .busy(busy),
    .out_valid(out_valid));

  perm_scan_ctrl #(.N_WORKER(5), .IDX_W(3), .PIPE_LAT(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .perm_valid(perm_valid_b), .perm_last(perm_last_b),
    .perm_ready(perm_ready_b), .worker_idx(worker_idx_b), .issue(issue_b), .acc_en(acc_en_b),
    .acc_first(acc_first_b), .acc_last(acc_last_b), .perm_count(perm_count_b), .busy(busy_b),
    .out_valid(out_valid_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  int         q_idx[$];
  logic [1:0] q_acc[$];
  int         q_icyc[$];
  int         q_done[$];
  int         last_icyc = 0;
  int         done_seen = 0;
  int         run = 0, max_run = 0, ready_cnt = 0, n_first = 0, n_last = 0;

  int q_idx_b[$];
  int q_done_b[$];
  int last_icyc_b = 0, done_seen_b = 0, n_last_b = 0;

  // Monitor for the default-parameter instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (issue) begin
        if (q_idx.size() == 0) check("unexpected_issue", 1, 0);
        else check("worker_idx", int'(worker_idx), q_idx.pop_front());
        q_icyc.push_back(cyc);
        last_icyc = cyc;
        run++;
        if (run > max_run) max_run = run;
        if (perm_ready) begin
          ready_cnt++;
          check("ready_at_last_idx", int'(worker_idx), NW - 1);
        end
      end else begin
        run = 0;
      end
      if (acc_en) begin
        if (q_acc.size() == 0) check("unexpected_acc_en", 1, 0);
        else check("acc_first_last", int'({acc_first, acc_last}), int'(q_acc.pop_front()));
        if (q_icyc.size() != 0) check("acc_latency", cyc - q_icyc.pop_front(), PL);
        n_first += int'(acc_first);
        n_last  += int'(acc_last);
      end else if (acc_first || acc_last) begin
        check("strobe_without_acc_en", 1, 0);
      end
      if (out_valid) begin
        if (q_done.size() == 0) check("unexpected_out_valid", 1, 0);
        else begin
          check("perm_count_at_done", int'(perm_count), q_done.pop_front());
          check("done_latency", cyc - last_icyc, PL + 1);
        end
        done_seen++;
      end
    end
  end

  // Monitor for the N_WORKER=5 / PIPE_LAT=1 / CNT_W=2 instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (issue_b) begin
        check("b_idx_in_range", int'(worker_idx_b < 3'd5), 1);
        if (q_idx_b.size() == 0) check("b_unexpected_issue", 1, 0);
        else check("b_worker_idx", int'(worker_idx_b), q_idx_b.pop_front());
        last_icyc_b = cyc;
      end
      if (acc_en_b) n_last_b += int'(acc_last_b);
      if (out_valid_b) begin
        if (q_done_b.size() == 0) check("b_unexpected_out_valid", 1, 0);
        else begin
          check("b_perm_count_sat", int'(perm_count_b), q_done_b.pop_front());
          check("b_done_latency", cyc - last_icyc_b, 2);
        end
        done_seen_b++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Offer one permutation and return just after the edge where it transfers.
  task automatic send_perm(input bit last);
    int t;
    perm_valid = 1'b1;
    perm_last  = last;
    for (int i = 0; i < NW; i++) begin
      q_idx.push_back(i);
      q_acc.push_back({i == 0, i == NW - 1});
    end
    t = 0;
    forever begin
      @(negedge clk);
      if (perm_ready) break;
      t++;
      if (t > 200) begin
        check("handshake_timeout", 0, 1);
        break;
      end
    end
    step();
  endtask

  task automatic wait_done();
    int d;
    d = done_seen;
    for (int t = 0; t < 100 && done_seen == d; t++) @(negedge clk);
    if (done_seen == d) check("done_timeout", 0, 1);
    step();
  endtask

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; perm_valid = 1'b0; perm_last = 1'b0;
    start_b = 1'b0; perm_valid_b = 1'b0; perm_last_b = 1'b0;
    repeat (3) step();
    check("rst_busy", int'(busy), 0);
    check("rst_issue", int'(issue), 0);
    check("rst_acc_en", int'(acc_en), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_perm_count", int'(perm_count), 0);
    check("rst_perm_ready", int'(perm_ready), 0);
    rst = 1'b0;
    step();

    // Reset mid-SCAN at idx 5 aborts the job.
    do_start();
    send_perm(1'b0);
    perm_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(issue && worker_idx == 3'd5) && t < 50);
    check("reached_idx5", int'(worker_idx), 5);
    rst = 1'b1;
    step();
    check("abort_busy", int'(busy), 0);
    check("abort_issue", int'(issue), 0);
    check("abort_acc_en", int'(acc_en), 0);
    q_idx.delete(); q_acc.delete(); q_icyc.delete();
    rst = 1'b0;
    repeat (20) step();
    check("abort_perm_count", int'(perm_count), 0);

    // Single permutation flagged last.
    q_done.push_back(1);
    do_start();
    send_perm(1'b1);
    perm_valid = 1'b0;
    wait_done();
    check("single_busy_after", int'(busy), 0);

    // Four permutations back-to-back.
    max_run = 0; ready_cnt = 0;
    q_done.push_back(4);
    do_start();
    send_perm(1'b0); send_perm(1'b0); send_perm(1'b0); send_perm(1'b1);
    perm_valid = 1'b0;
    wait_done();
    check("contiguous_issue", max_run, 32);
    check("b2b_ready_pulses", ready_cnt, 3);

    // Generator stalls between permutations.
    n_first = 0; n_last = 0;
    q_done.push_back(3);
    do_start();
    for (int p = 0; p < 3; p++) begin
      send_perm(p == 2);
      perm_valid = 1'b0;
      if (p < 2) begin
        repeat (NW) step();
        for (int s = 0; s < 5; s++) begin
          check("stall_issue", int'(issue), 0);
          check("stall_busy", int'(busy), 1);
          step();
        end
      end
    end
    wait_done();
    check("acc_first_count", n_first, 3);
    check("acc_last_count", n_last, 3);

    // start while busy is ignored.
    q_done.push_back(2);
    do_start();
    send_perm(1'b0);
    perm_valid = 1'b0;
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    check("start_ignored_busy", int'(busy), 1);
    send_perm(1'b1);
    perm_valid = 1'b0;
    wait_done();

    // Small instance: 5 workers, 6 permutations, 2-bit saturating count.
    q_done_b.push_back(3);
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    perm_valid_b = 1'b1;
    for (int k = 0; k < 6; k++) begin
      perm_last_b = (k == 5);
      for (int i = 0; i < 5; i++) q_idx_b.push_back(i);
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!perm_ready_b && t < 100);
      if (!perm_ready_b) check("b_handshake_timeout", 0, 1);
      step();
    end
    perm_valid_b = 1'b0;
    t = 0;
    while (done_seen_b == 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("b_done_seen", done_seen_b, 1);
    step();
    check("b_acc_last_count", n_last_b, 6);

    check("leftover_expectations",
          q_idx.size() + q_acc.size() + q_done.size() + q_idx_b.size() + q_done_b.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
